// File: rtl/crc_frame_pkg.sv
// Shared types and CRC-16/CCITT-FALSE helpers for the frame checker and other CRC blocks.
package crc_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CRC_HI  = 3'd3,
        CRC_LO  = 3'd4
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // MSB-first byte update, no reflection, no final XOR.
    function automatic logic [15:0] crc16_ccitt_update(input logic [15:0] crc_in,
                                                       input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_frame_check_if.sv
// Byte-in / frame-result bus between the UART receiver side and the frame checker.
interface crc_frame_check_if;

    logic        data_en;
    logic [7:0]  data_in;
    logic        payload_valid;
    logic [7:0]  payload_data;
    logic        frame_done;
    logic        crc_ok;
    logic [15:0] crc_calc;
    logic        len_err;
    logic        timeout_err;

    modport master (
        output data_en, data_in,
        input  payload_valid, payload_data, frame_done, crc_ok, crc_calc,
               len_err, timeout_err
    );

    modport slave (
        input  data_en, data_in,
        output payload_valid, payload_data, frame_done, crc_ok, crc_calc,
               len_err, timeout_err
    );

endinterface

// File: rtl/crc16_ccitt_byte.sv
// Combinational one-byte CRC-16/CCITT-FALSE update, shared by CRC blocks in the codebase.
module crc16_ccitt_byte
    import crc_frame_pkg::*;
(
    input  logic [15:0] i_crc_in,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc_out
);

    assign o_crc_out = crc16_ccitt_update(i_crc_in, i_byte);

endmodule

// File: rtl/crc_frame_check.sv
// Frame parser (header, length, payload, CRC hi/lo) with payload CRC-16 check,
// length-error and inter-byte timeout reporting. All outputs registered.
module crc_frame_check
    import crc_frame_pkg::*;
#(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         MAX_LEN     = 64,
    parameter int         TIMEOUT_CYC = 156250,
    parameter int         TO_WIDTH    = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    crc_frame_check_if.slave bus
);

    state_t              r_state;
    logic [7:0]          r_len_cnt;
    logic [7:0]          r_crc_hi;
    logic [15:0]         r_crc;
    logic [TO_WIDTH-1:0] r_to_cnt;
    logic                r_payload_valid;
    logic [7:0]          r_payload_data;
    logic                r_frame_done;
    logic                r_crc_ok;
    logic [15:0]         r_crc_calc;
    logic                r_len_err;
    logic                r_timeout_err;

    state_t              w_state_nxt;
    logic [7:0]          w_len_nxt;
    logic [7:0]          w_hi_nxt;
    logic [15:0]         w_crc_nxt;
    logic [TO_WIDTH-1:0] w_to_cnt_nxt;
    logic                w_pv_nxt;
    logic [7:0]          w_pdata_nxt;
    logic                w_fd_nxt;
    logic                w_ok_nxt;
    logic [15:0]         w_calc_nxt;
    logic                w_le_nxt;
    logic                w_to_nxt;
    logic [15:0]         w_crc_upd;
    logic                w_to_hit;

    crc16_ccitt_byte u_crc (
        .i_crc_in  (r_crc),
        .i_byte    (bus.data_in),
        .o_crc_out (w_crc_upd)
    );

    assign w_to_hit = (r_to_cnt == TO_WIDTH'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len_cnt;
        w_hi_nxt     = r_crc_hi;
        w_crc_nxt    = r_crc;
        w_pv_nxt     = 1'b0;
        w_pdata_nxt  = r_payload_data;
        w_fd_nxt     = 1'b0;
        w_ok_nxt     = r_crc_ok;
        w_calc_nxt   = r_crc_calc;
        w_le_nxt     = 1'b0;
        w_to_nxt     = 1'b0;
        w_to_cnt_nxt = (bus.data_en || (r_state == IDLE)) ? '0
                                                          : r_to_cnt + TO_WIDTH'(1);

        // A byte arriving on the terminal count cycle takes priority over the timeout.
        if (bus.data_en) begin
            case (r_state)
                IDLE: begin
                    if (bus.data_in == HEADER) begin
                        w_crc_nxt   = CRC_INIT;
                        w_state_nxt = LEN;
                    end
                end
                LEN: begin
                    w_len_nxt = bus.data_in;
                    if (bus.data_in > 8'(MAX_LEN)) begin
                        w_le_nxt    = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (bus.data_in == 8'd0) begin
                        w_state_nxt = CRC_HI;
                    end else begin
                        w_state_nxt = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    w_pv_nxt    = 1'b1;
                    w_pdata_nxt = bus.data_in;
                    w_crc_nxt   = w_crc_upd;
                    w_len_nxt   = r_len_cnt - 8'd1;
                    if (r_len_cnt == 8'd1) begin
                        w_state_nxt = CRC_HI;
                    end
                end
                CRC_HI: begin
                    w_hi_nxt    = bus.data_in;
                    w_state_nxt = CRC_LO;
                end
                CRC_LO: begin
                    w_fd_nxt    = 1'b1;
                    w_ok_nxt    = ({r_crc_hi, bus.data_in} == r_crc);
                    w_calc_nxt  = r_crc;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end else if ((r_state != IDLE) && w_to_hit) begin
            w_to_nxt     = 1'b1;
            w_to_cnt_nxt = '0;
            w_state_nxt  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_len_cnt       <= 8'd0;
            r_crc_hi        <= 8'd0;
            r_crc           <= CRC_INIT;
            r_to_cnt        <= '0;
            r_payload_valid <= 1'b0;
            r_payload_data  <= 8'd0;
            r_frame_done    <= 1'b0;
            r_crc_ok        <= 1'b0;
            r_crc_calc      <= 16'd0;
            r_len_err       <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_len_cnt       <= w_len_nxt;
            r_crc_hi        <= w_hi_nxt;
            r_crc           <= w_crc_nxt;
            r_to_cnt        <= w_to_cnt_nxt;
            r_payload_valid <= w_pv_nxt;
            r_payload_data  <= w_pdata_nxt;
            r_frame_done    <= w_fd_nxt;
            r_crc_ok        <= w_ok_nxt;
            r_crc_calc      <= w_calc_nxt;
            r_len_err       <= w_le_nxt;
            r_timeout_err   <= w_to_nxt;
        end
    end

    assign bus.payload_valid = r_payload_valid;
    assign bus.payload_data  = r_payload_data;
    assign bus.frame_done    = r_frame_done;
    assign bus.crc_ok        = r_crc_ok;
    assign bus.crc_calc      = r_crc_calc;
    assign bus.len_err       = r_len_err;
    assign bus.timeout_err   = r_timeout_err;

endmodule
